// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock FIFO with a registered read port,
// an occupancy count, threshold flags and optional sticky error flags.
// Ports: clk, rst (sync, active-high), data_in/push (write side),
//   pop -> data_out/valid (registered read side, one-cycle latency),
//   full/empty/almost_full/almost_empty/count (status from registered count),
//   overflow/underflow (sticky; live only with PARAM_SYNC_FIFO_ERR_FLAGS_EN).
module param_sync_fifo #(
  parameter int WIDTH     = 2,
  parameter int DEPTH     = 4,
  parameter bit OVERWRITE = 1'b0,
  parameter int AF_LEVEL  = DEPTH - 1,
  parameter int AE_LEVEL  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            data_in,
  input  logic                        push,
  input  logic                        pop,
  output logic [WIDTH-1:0]            data_out,
  output logic                        valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C   = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0] CNT_1  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_1 = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  logic pop_ok;
  logic push_ok;
  logic evict;
  logic inc;
  logic dec;

  assign full         = (count == FULL_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A full FIFO still takes a push when a pop frees the slot in the same
  // cycle; with OVERWRITE the oldest word is evicted instead.
  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok || OVERWRITE);
    evict   = push_ok && full && !pop_ok;
    inc     = push_ok && !pop_ok && !evict;
    dec     = pop_ok && !push_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      valid    <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      valid <= pop_ok;
      if (pop_ok)
        data_out <= mem[rd_ptr];
      if (pop_ok || evict)
        rd_ptr <= rd_ptr + PTR_1;
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_1;
      if (inc)
        count <= count + CNT_1;
      else if (dec)
        count <= count - CNT_1;
    end
  end

  // Storage is not reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (!rst && push_ok)
      mem[wr_ptr] <= data_in;
  end

`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Covers both a dropped word and an overwrite eviction.
      if (push && full && !pop_ok)
        overflow <= 1'b1;
      if (pop && empty)
        underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: checks two param_sync_fifo instances (drop and
// overwrite policies, WIDTH=2 DEPTH=4) against a queue-based model.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic       pop;
  logic [1:0] data_in;

  logic [1:0] dout [2];
  logic [2:0] cnt  [2];
  logic       vld  [2];
  logic       ful  [2];
  logic       emp  [2];
  logic       af   [2];
  logic       ae   [2];
  logic       ovf  [2];
  logic       udf  [2];

  int errors = 0;
  int checks = 0;

  // Reference model state, one per instance (index 1 = overwrite policy).
  logic [1:0] mq [2][$];
  logic [1:0] mdout [2];
  bit         mv [2];
  bit         mo [2];
  bit         mu [2];

  always #5 clk = ~clk;

  param_sync_fifo #(.WIDTH(2), .DEPTH(4), .OVERWRITE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .push(push), .pop(pop),
    .data_out(dout[0]), .valid(vld[0]), .full(ful[0]), .empty(emp[0]),
    .almost_full(af[0]), .almost_empty(ae[0]), .count(cnt[0]),
    .overflow(ovf[0]), .underflow(udf[0])
  );

  param_sync_fifo #(.WIDTH(2), .DEPTH(4), .OVERWRITE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .push(push), .pop(pop),
    .data_out(dout[1]), .valid(vld[1]), .full(ful[1]), .empty(emp[1]),
    .almost_full(af[1]), .almost_empty(ae[1]), .count(cnt[1]),
    .overflow(ovf[1]), .underflow(udf[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_update(input int m, input bit r, input bit p,
                              input bit q, input logic [1:0] d);
    bit ow;
    ow = (m == 1);
    mv[m] = 1'b0;
    if (r) begin
      mq[m].delete();
      mdout[m] = 2'b00;
      mo[m] = 1'b0;
      mu[m] = 1'b0;
    end else begin
      if (q) begin
        if (mq[m].size() > 0) begin
          mdout[m] = mq[m].pop_front();
          mv[m] = 1'b1;
        end else begin
          mu[m] = 1'b1;
        end
      end
      if (p) begin
        if (mq[m].size() < 4) begin
          mq[m].push_back(d);
        end else begin
          mo[m] = 1'b1;
          if (ow) begin
            void'(mq[m].pop_front());
            mq[m].push_back(d);
          end
        end
      end
    end
  endtask

  task automatic check_all();
    int n;
    bit eo;
    bit eu;
    for (int m = 0; m < 2; m++) begin
      n = mq[m].size();
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
      eo = mo[m];
      eu = mu[m];
`else
      eo = 1'b0;
      eu = 1'b0;
`endif
      chk($sformatf("dut%0d count", m), 32'(cnt[m]), 32'(n));
      chk($sformatf("dut%0d data_out", m), 32'(dout[m]), 32'(mdout[m]));
      chk($sformatf("dut%0d valid", m), 32'(vld[m]), 32'(mv[m]));
      chk($sformatf("dut%0d full", m), 32'(ful[m]), 32'(n == 4));
      chk($sformatf("dut%0d empty", m), 32'(emp[m]), 32'(n == 0));
      chk($sformatf("dut%0d almost_full", m), 32'(af[m]), 32'(n >= 3));
      chk($sformatf("dut%0d almost_empty", m), 32'(ae[m]), 32'(n <= 1));
      chk($sformatf("dut%0d overflow", m), 32'(ovf[m]), 32'(eo));
      chk($sformatf("dut%0d underflow", m), 32'(udf[m]), 32'(eu));
    end
  endtask

  task automatic step(input bit r, input bit p, input bit q,
                      input logic [1:0] d);
    rst = r;
    push = p;
    pop = q;
    data_in = d;
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_update(m, r, p, q, d);
    #1;
    check_all();
  endtask

  typedef struct {
    bit         p;
    bit         q;
    logic [1:0] d;
    int         c0;
    int         d0;
    bit         v0;
    int         c1;
    int         d1;
    bit         v1;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int bias;
    bit r;
    bit p;
    bit q;

    // push x4, push while full, pop x4, pop while empty x2, idle
    tbl[0]  = '{1, 0, 2'b10, 1, 0, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 2'b11, 2, 0, 0, 2, 0, 0};
    tbl[2]  = '{1, 0, 2'b01, 3, 0, 0, 3, 0, 0};
    tbl[3]  = '{1, 0, 2'b11, 4, 0, 0, 4, 0, 0};
    tbl[4]  = '{1, 0, 2'b01, 4, 0, 0, 4, 0, 0};
    tbl[5]  = '{0, 1, 2'b00, 3, 2, 1, 3, 3, 1};
    tbl[6]  = '{0, 1, 2'b00, 2, 3, 1, 2, 1, 1};
    tbl[7]  = '{0, 1, 2'b00, 1, 1, 1, 1, 3, 1};
    tbl[8]  = '{0, 1, 2'b00, 0, 3, 1, 0, 1, 1};
    tbl[9]  = '{0, 1, 2'b00, 0, 3, 0, 0, 1, 0};
    tbl[10] = '{0, 1, 2'b00, 0, 3, 0, 0, 1, 0};
    tbl[11] = '{0, 0, 2'b00, 0, 3, 0, 0, 1, 0};

    rst = 1'b1;
    push = 1'b0;
    pop = 1'b0;
    data_in = 2'b00;
    step(1, 0, 0, 2'b00);
    step(1, 0, 0, 2'b00);

    for (int i = 0; i < 12; i++) begin
      step(0, tbl[i].p, tbl[i].q, tbl[i].d);
      chk($sformatf("vec%0d dut0 count", i), 32'(cnt[0]), 32'(tbl[i].c0));
      chk($sformatf("vec%0d dut0 data", i), 32'(dout[0]), 32'(tbl[i].d0));
      chk($sformatf("vec%0d dut0 valid", i), 32'(vld[0]), 32'(tbl[i].v0));
      chk($sformatf("vec%0d dut1 count", i), 32'(cnt[1]), 32'(tbl[i].c1));
      chk($sformatf("vec%0d dut1 data", i), 32'(dout[1]), 32'(tbl[i].d1));
      chk($sformatf("vec%0d dut1 valid", i), 32'(vld[1]), 32'(tbl[i].v1));
    end

    // Steady state at count 2 with simultaneous push and pop, pointers wrap.
    step(1, 0, 0, 2'b00);
    step(0, 1, 0, 2'd0);
    step(0, 1, 0, 2'd1);
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 1, 2'(k + 2));
      chk($sformatf("pp%0d count", k), 32'(cnt[0]), 32'd2);
      chk($sformatf("pp%0d data", k), 32'(dout[0]), 32'(k % 4));
      chk($sformatf("pp%0d valid", k), 32'(vld[0]), 32'd1);
    end

    // Reset while full, with push and pop asserted.
    for (int k = 0; k < 4; k++) step(0, 1, 0, 2'(k));
    step(0, 0, 1, 2'b00);
    step(0, 1, 0, 2'b11);
    step(1, 1, 1, 2'b10);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rstfull dut%0d count", m), 32'(cnt[m]), 32'd0);
      chk($sformatf("rstfull dut%0d empty", m), 32'(emp[m]), 32'd1);
      chk($sformatf("rstfull dut%0d valid", m), 32'(vld[m]), 32'd0);
      chk($sformatf("rstfull dut%0d data", m), 32'(dout[m]), 32'd0);
      chk($sformatf("rstfull dut%0d ovf", m), 32'(ovf[m]), 32'd0);
    end

    // Randomised traffic with drifting push/pop bias and rare resets.
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) bias = $urandom_range(15, 85);
      r = ($urandom_range(0, 199) == 0);
      p = ($urandom_range(0, 99) < bias);
      q = ($urandom_range(0, 99) < 100 - bias);
      step(r, p, q, 2'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO that replaces the fixed four-deep, two-bit queue. Width, depth, full-push policy and almost-full/almost-empty thresholds are configurable. The block has registered read data with a valid strobe, an occupancy count and defined simultaneous push/pop behaviour. It sits between producer and consumer stages in the same clock domain and is the standard buffering primitive for new datapaths.

## Interface
Parameters:
- WIDTH, 2, data word width in bits (>=1)
- DEPTH, 4, number of entries; power of two, >=2
- OVERWRITE, 0, full-push policy: 0 = drop the new word, 1 = discard the oldest word and accept the new one
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL
- Derived localparam AW = log2(DEPTH)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  WIDTH  write data, sampled when push is high
- push  in  1  write request, level-sampled each cycle
- pop  in  1  read request, level-sampled each cycle
- data_out  out  WIDTH  registered read data; holds its last value between pops
- valid  out  1  one-cycle pulse: data_out was updated by an accepted pop
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky error flag; see Configuration
- underflow  out  1  sticky error flag; see Configuration

## Operation
- Storage is a DEPTH x WIDTH array. Read and write pointers are AW bits wide and wrap modulo DEPTH. The array contents are not reset.
- Pop acceptance:
  - Accepted when push and pop are both high, or when only pop is high, whenever count > 0.
  - An accepted pop loads mem[rd_ptr] into data_out, pulses valid and advances rd_ptr.
- Push acceptance:
  - Accepted when count < DEPTH.
  - Also accepted when count == DEPTH and the same-cycle pop is accepted; the slot is freed in that cycle.
  - Also accepted when count == DEPTH, no pop, and OVERWRITE=1.
  - An accepted push writes data_in to mem[wr_ptr] and advances wr_ptr.
- Full, push, no pop:
  - OVERWRITE=0: the word is dropped and no state changes.
  - OVERWRITE=1: the word is written at wr_ptr and both pointers advance. count stays DEPTH. data_out and valid are unchanged; the evicted word is not presented.
- Empty, pop, with or without push: the pop is ignored. data_out holds and valid=0. A concurrent push is accepted normally, with no bypass.
- count update: +1 for push-only accepted, -1 for pop-only accepted, unchanged for both or neither. No other arithmetic.
- Flags are decoded from the registered count and change on the same edge as count.

## Timing
- Read latency: an accepted pop in cycle N gives data_out and valid=1 in cycle N+1. valid returns low in N+2 unless another pop is accepted.
- Write-to-read: a word pushed in cycle N is poppable from cycle N+1. The earliest data_out is N+2.
- Back-to-back push and pop every cycle are sustained at full throughput.
- Reset values: data_out=0, valid=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0. Both pointers are 0.
- rst dominates push and pop in the same cycle. Reset mid-operation discards all contents in one cycle.

## Configuration
- Macro: PARAM_SYNC_FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on a push while full with OVERWRITE=0 and no accepted pop, or on any overwrite eviction.
  - underflow sets on a pop while empty.
  - Both flags are sticky until rst and are visible the cycle after the event.
- Undefined: overflow and underflow are tied to 0 and the detection logic is compiled out. The ports remain present.

## Test plan
All scenarios use WIDTH=2, DEPTH=4 and the default thresholds.
- Reset, then push 10,11,01,11 on consecutive cycles -> count 1,2,3,4; almost_full at count 3; full at 4; empty deasserts after the first edge.
- Full with OVERWRITE=0; push 01; then pop 4 times -> count stays 4; pops return 10,11,01,11, each with a one-cycle valid; empty=1 after the last; overflow=1 when the macro is defined.
- Full with OVERWRITE=1; push 01; then pop 4 times -> pops return 11,01,11,01; count never exceeds 4.
- Empty; assert pop for 2 cycles -> valid stays 0; data_out holds the previous value; underflow=1 when the macro is defined.
- count=2; push and pop together for 6 cycles with incrementing data -> count stays 2; pointers wrap cleanly; read order matches write order.
- Full; assert rst together with push and pop -> next cycle count=0, empty=1, valid=0, data_out=0, flags clear.
